// File: rtl/dco_param.sv
// dco_param: parametrised counter-based digitally controlled oscillator.
//
// Converts a sign-magnitude loop-filter word into a half-period threshold. The
// counter runs from 0 to the latched threshold, and dco_clk toggles when the
// count reaches that threshold. Each half-period therefore lasts thr_q+1 enabled
// cycles. A new threshold is latched only at a toggle, so a change on the inputs
// mid-half-period never produces a short or glitched half cycle.
//
// Optional feature macro: DCO_DITHER_EN
//   When it is defined, an FW-bit fractional accumulator adds frac at every toggle.
//   On carry-out, the loaded threshold is stretched by one cycle (saturating at
//   2^W-1), so the average half-period is thr_next+1+frac/2^FW cycles.
//   When it is undefined, i_frac is ignored and thr_q loads thr_next exactly.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset (wins over i_en)
//   i_en           1 = run, 0 = freeze counter, dco_clk and all state
//   i_ctrl_sign    0 = ctrl positive (faster), 1 = ctrl negative (slower)
//   i_ctrl         [CW] control magnitude
//   i_kdco         [KW] DCO gain
//   i_thresh_val   [W]  nominal half-period threshold
//   i_dco_offset   [W]  threshold offset
//   i_frac         [FW] dither fraction (dither build only)
//   o_dco_clk      DCO output clock
//   o_dco_edge     high for the first cycle o_dco_clk reads 1
//   o_thr_q        [W]  threshold currently in use
//   o_sat_hi       last threshold load clamped high
//   o_sat_lo       last threshold load clamped low
module dco_param #(
  parameter int W     = 8,
  parameter int CW    = 5,
  parameter int KW    = 5,
  parameter int SHIFT = 1,
  parameter int FW    = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic          i_ctrl_sign,
  input  logic [CW-1:0] i_ctrl,
  input  logic [KW-1:0] i_kdco,
  input  logic [W-1:0]  i_thresh_val,
  input  logic [W-1:0]  i_dco_offset,
  input  logic [FW-1:0] i_frac,
  output logic          o_dco_clk,
  output logic          o_dco_edge,
  output logic [W-1:0]  o_thr_q,
  output logic          o_sat_hi,
  output logic          o_sat_lo
);

  localparam int PW = CW + KW;
  localparam int SW = W + CW + KW + 2;
  localparam logic signed [SW-1:0] THR_MAX = $signed(SW'({W{1'b1}}));

  // Load word layout: {sat_hi, sat_lo, threshold[W-1:0]}.
  function automatic logic [W+1:0] sat_thr(input logic signed [SW-1:0] s);
    if (s < 0)
      return {1'b0, 1'b1, {W{1'b0}}};
    else if (s > THR_MAX)
      return {1'b1, 1'b0, {W{1'b1}}};
    else
      return {2'b00, s[W-1:0]};
  endfunction

  // Stretch a load by one cycle on dither carry; an already-full threshold stays
  // at 2^W-1 and reports the clamp through sat_hi.
  function automatic logic [W+1:0] dither_bump(input logic [W+1:0] t,
                                               input logic carry);
    if (!carry)
      return t;
    else if (&t[W-1:0])
      return {1'b1, t[W], t[W-1:0]};
    else
      return {t[W+1:W], t[W-1:0] + W'(1)};
  endfunction

  logic [PW-1:0]          w_prod;
  logic [PW-1:0]          w_phase;
  logic signed [SW-1:0]   w_base;
  logic signed [SW-1:0]   w_ph;
  logic signed [SW-1:0]   w_sum;
  logic [W+1:0]           w_clamp;
  logic [W+1:0]           w_load;
  logic                   w_toggle;

  logic [W-1:0]           r_cnt;
  logic [W-1:0]           r_thr;
  logic                   r_dco_clk;
  logic                   r_edge;
  logic                   r_sat_hi;
  logic                   r_sat_lo;

  // Wide signed sum so that neither underflow nor overflow wraps before clamping.
  assign w_prod   = PW'(i_ctrl) * PW'(i_kdco);
  assign w_phase  = w_prod >> SHIFT;
  assign w_base   = $signed(SW'(i_thresh_val)) + $signed(SW'(i_dco_offset));
  assign w_ph     = $signed(SW'(w_phase));
  assign w_sum    = i_ctrl_sign ? (w_base + w_ph) : (w_base - w_ph);
  assign w_clamp  = sat_thr(w_sum);
  assign w_toggle = (r_cnt >= r_thr);

`ifdef DCO_DITHER_EN
  logic [FW-1:0] r_acc;
  logic [FW:0]   w_acc_sum;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, i_frac};
  assign w_load    = dither_bump(w_clamp, w_acc_sum[FW]);

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_acc <= '0;
    else if (i_en && w_toggle)
      r_acc <= w_acc_sum[FW-1:0];
  end
`else
  logic w_frac_unused;

  assign w_frac_unused = ^i_frac;
  assign w_load        = dither_bump(w_clamp, 1'b0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_thr     <= '0;
      r_dco_clk <= 1'b0;
      r_edge    <= 1'b0;
      r_sat_hi  <= 1'b0;
      r_sat_lo  <= 1'b0;
    end else if (i_en) begin
      if (w_toggle) begin
        r_cnt     <= '0;
        r_dco_clk <= ~r_dco_clk;
        // Strobe only on the 0 -> 1 toggle.
        r_edge    <= ~r_dco_clk;
        r_thr     <= w_load[W-1:0];
        r_sat_lo  <= w_load[W];
        r_sat_hi  <= w_load[W+1];
      end else begin
        // r_cnt < r_thr here, so the increment cannot pass 2^W-1.
        r_cnt     <= r_cnt + W'(1);
        r_edge    <= 1'b0;
      end
    end else begin
      r_edge <= 1'b0;
    end
  end

  assign o_dco_clk  = r_dco_clk;
  assign o_dco_edge = r_edge;
  assign o_thr_q    = r_thr;
  assign o_sat_hi   = r_sat_hi;
  assign o_sat_lo   = r_sat_lo;

endmodule
